// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data-memory port between the MIPS CPU execute-stage memory
// interface and a host requester (DMA engine, program loader). The CPU owns the
// port by default. The host gets idle slots for free and gets a forced burst
// once it has been denied MAX_WAIT consecutive enabled cycles. While the CPU is
// frozen by a burst, the last CPU load result is held stable on
// cpu_mem_read_data.
//
// State table
//   state      | meaning
//   -----------+---------------------------------------------------------------
//   CPU_OWN    | CPU drives the bus; host only steals cycles with no CPU access
//   HOST_BURST | CPU frozen (cpu_en=0); host owns the bus for up to BURST_MAX
//              | beats or until it drops host_req
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   en_in               global enable; low = no grants, all state holds
//   cpu_en              enable to mips_cpu
//   cpu_mem_*           CPU memory request in / load data out
//   host_req/we/addr/   host beat request and attributes (held until granted)
//   host_wdata
//   host_gnt            host beat issued on the bus this cycle
//   host_rvalid/rdata   host read data, one cycle after a read grant
//   mem_*               data-memory port (synchronous read, 1-cycle latency)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT  = 15,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_in,
    output logic        cpu_en,

    input  logic [3:0]  cpu_mem_write_en,
    input  logic        cpu_mem_read_en,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_write_data,
    output logic [31:0] cpu_mem_read_data,

    input  logic        host_req,
    input  logic [3:0]  host_we,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_gnt,
    output logic        host_rvalid,
    output logic [31:0] host_rdata,

    output logic [3:0]  mem_write_en,
    output logic        mem_read_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int BEAT_W = $clog2(BURST_MAX + 1);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);

    typedef enum logic {
        CPU_OWN    = 1'b0,
        HOST_BURST = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_cnt_nxt;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [BEAT_W-1:0]   w_beat_cnt_nxt;

    logic                r_cpu_rd_last;
    logic [31:0]         r_hold;
    logic                r_host_rvalid;

    logic                w_active;
    logic                w_cpu_access;
    logic                w_host_gnt;
    logic                w_cpu_en;
    logic                w_cpu_bus;
    logic                w_host_rd;

    // Reset is folded into the enable so that no grant, CPU enable or bus
    // activity can appear in the reset cycle, whatever state we are leaving.
    assign w_active     = en_in & ~rst;
    assign w_cpu_access = (|cpu_mem_write_en) | cpu_mem_read_en;
    assign w_host_rd    = (host_we == 4'h0);

    // -------------------------------------------------------------------------
    // Next-state, counters and grant decisions
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_beat_cnt_nxt = r_beat_cnt;
        w_host_gnt     = 1'b0;
        w_cpu_en       = 1'b0;
        w_cpu_bus      = 1'b0;

        case (r_state)
            CPU_OWN: begin
                w_cpu_en   = w_active;
                // CPU wins any collision; host only fills empty slots here.
                w_host_gnt = w_active & host_req & ~w_cpu_access;
                w_cpu_bus  = w_active & w_cpu_access & ~w_host_gnt;

                if (w_active) begin
                    if (host_req && !w_host_gnt) begin
                        if (r_wait_cnt == WAIT_LAST) begin
                            w_state_nxt    = HOST_BURST;
                            w_wait_cnt_nxt = '0;
                            w_beat_cnt_nxt = '0;
                        end else begin
                            w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                        end
                    end else begin
                        w_wait_cnt_nxt = '0;
                    end
                end
            end

            HOST_BURST: begin
                // The CPU is frozen; its pending request is never forwarded,
                // so a stalled store cannot reach memory twice.
                w_host_gnt = w_active & host_req;

                if (w_active) begin
                    if (!host_req) begin
                        w_state_nxt    = CPU_OWN;
                        w_beat_cnt_nxt = '0;
                    end else if (r_beat_cnt == BEAT_LAST) begin
                        w_state_nxt    = CPU_OWN;
                        w_beat_cnt_nxt = '0;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt    = CPU_OWN;
                w_wait_cnt_nxt = '0;
                w_beat_cnt_nxt = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Memory bus mux: host beat, CPU access, or all-zero when nothing issues
    // -------------------------------------------------------------------------
    always_comb begin
        mem_write_en   = 4'h0;
        mem_read_en    = 1'b0;
        mem_addr       = 32'h0;
        mem_write_data = 32'h0;

        if (w_host_gnt) begin
            mem_write_en   = host_we;
            mem_read_en    = w_host_rd;
            mem_addr       = host_addr;
            mem_write_data = host_wdata;
        end else if (w_cpu_bus) begin
            mem_write_en   = cpu_mem_write_en;
            mem_read_en    = cpu_mem_read_en;
            mem_addr       = cpu_mem_addr;
            mem_write_data = cpu_mem_write_data;
        end
    end

    // -------------------------------------------------------------------------
    // State and data registers; everything freezes while en_in is low
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= CPU_OWN;
            r_wait_cnt    <= '0;
            r_beat_cnt    <= '0;
            r_cpu_rd_last <= 1'b0;
            r_hold        <= 32'h0;
            r_host_rvalid <= 1'b0;
        end else if (en_in) begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_beat_cnt    <= w_beat_cnt_nxt;
            r_cpu_rd_last <= w_cpu_bus & cpu_mem_read_en;
            r_host_rvalid <= w_host_gnt & w_host_rd;
            // Capture the CPU load result in the cycle it returns so it stays
            // visible after the memory output moves on to host data.
            if (r_cpu_rd_last) begin
                r_hold <= mem_read_data;
            end
        end
    end

    assign cpu_en            = w_cpu_en;
    assign host_gnt          = w_host_gnt;
    assign host_rvalid       = r_host_rvalid;
    assign host_rdata        = mem_read_data;
    assign cpu_mem_read_data = r_cpu_rd_last ? mem_read_data : r_hold;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_in;
    logic        cpu_en;
    logic [3:0]  cpu_mem_write_en;
    logic        cpu_mem_read_en;
    logic [31:0] cpu_mem_addr;
    logic [31:0] cpu_mem_write_data;
    logic [31:0] cpu_mem_read_data;
    logic        host_req;
    logic [3:0]  host_we;
    logic [31:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_gnt;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic [3:0]  mem_write_en;
    logic        mem_read_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data = 32'h0;

    int n_chk = 0;
    int n_bad = 0;

    dmem_arbiter #(.MAX_WAIT(15), .BURST_MAX(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .en_in              (en_in),
        .cpu_en             (cpu_en),
        .cpu_mem_write_en   (cpu_mem_write_en),
        .cpu_mem_read_en    (cpu_mem_read_en),
        .cpu_mem_addr       (cpu_mem_addr),
        .cpu_mem_write_data (cpu_mem_write_data),
        .cpu_mem_read_data  (cpu_mem_read_data),
        .host_req           (host_req),
        .host_we            (host_we),
        .host_addr          (host_addr),
        .host_wdata         (host_wdata),
        .host_gnt           (host_gnt),
        .host_rvalid        (host_rvalid),
        .host_rdata         (host_rdata),
        .mem_write_en       (mem_write_en),
        .mem_read_en        (mem_read_en),
        .mem_addr           (mem_addr),
        .mem_write_data     (mem_write_data),
        .mem_read_data      (mem_read_data)
    );

    always #5 clk = ~clk;

    // Read-only memory image: only the two locations the bench reads from.
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        if (a == 32'h80)  return 32'h11111111;
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        if (mem_read_en) mem_read_data <= rom(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic cpu_set(input logic [3:0] we, input logic re, input logic [31:0] a, input logic [31:0] d);
        cpu_mem_write_en   = we;
        cpu_mem_read_en    = re;
        cpu_mem_addr       = a;
        cpu_mem_write_data = d;
    endtask

    task automatic host_set(input logic req, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        host_req   = req;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic prev;
        logic burst;
        logic gnt_e;
        logic en_e;
        int   n_st;

        // ---------------- reset outputs gated ----------------
        rst   = 1'b1;
        en_in = 1'b1;
        cpu_set(4'h0, 1'b1, 32'h100, 32'h0);
        host_set(1'b1, 4'hF, 32'h40, 32'h12345678);
        #2;
        chk("rst_gnt",   {31'h0, host_gnt}, 32'h0);
        chk("rst_cpuen", {31'h0, cpu_en}, 32'h0);
        chk("rst_mwe",   {28'h0, mem_write_en}, 32'h0);
        chk("rst_mre",   {31'h0, mem_read_en}, 32'h0);
        chk("rst_maddr", mem_addr, 32'h0);
        step();
        do_reset();

        // ---------------- forced burst + CPU load hold ----------------
        cpu_set(4'h0, 1'b1, 32'h100, 32'h0);
        host_set(1'b1, 4'h0, 32'h80, 32'h0);
        prev = 1'b0;
        for (int c = 0; c <= 36; c++) begin
            #1;
            burst = (c >= 15 && c <= 18) || (c >= 34);
            chk($sformatf("A%0d_gnt", c),   {31'h0, host_gnt}, {31'h0, burst});
            chk($sformatf("A%0d_cpuen", c), {31'h0, cpu_en}, {31'h0, ~burst});
            chk($sformatf("A%0d_rvalid", c), {31'h0, host_rvalid}, {31'h0, prev});
            chk($sformatf("A%0d_maddr", c), mem_addr, burst ? 32'h80 : 32'h100);
            chk($sformatf("A%0d_mre", c),   {31'h0, mem_read_en}, 32'h1);
            chk($sformatf("A%0d_cpurd", c), cpu_mem_read_data, (c == 0) ? 32'h0 : 32'hDEADBEEF);
            if (prev) chk($sformatf("A%0d_hrdata", c), host_rdata, 32'h11111111);
            prev = burst;
            step();
        end

        // ---------------- idle-slot steal, gating, CPU priority ----------------
        do_reset();
        cpu_set(4'h0, 1'b0, 32'h123, 32'h55);
        host_set(1'b1, 4'hF, 32'h40, 32'hA5A5A5A5);
        #1;
        chk("B_gnt",   {31'h0, host_gnt}, 32'h1);
        chk("B_cpuen", {31'h0, cpu_en}, 32'h1);
        chk("B_mwe",   {28'h0, mem_write_en}, 32'hF);
        chk("B_mre",   {31'h0, mem_read_en}, 32'h0);
        chk("B_maddr", mem_addr, 32'h40);
        chk("B_mwd",   mem_write_data, 32'hA5A5A5A5);
        step();
        host_set(1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("B_rvalid_wr", {31'h0, host_rvalid}, 32'h0);
        chk("B_idle_maddr", mem_addr, 32'h0);
        chk("B_idle_mwd",   mem_write_data, 32'h0);
        chk("B_idle_gnt",   {31'h0, host_gnt}, 32'h0);
        step();
        cpu_set(4'h0, 1'b1, 32'h123, 32'h55);
        host_set(1'b1, 4'hF, 32'h40, 32'hA5A5A5A5);
        #1;
        chk("B_prio_gnt",   {31'h0, host_gnt}, 32'h0);
        chk("B_prio_maddr", mem_addr, 32'h123);
        step();

        // ---------------- CPU store held across a burst ----------------
        do_reset();
        cpu_set(4'hF, 1'b0, 32'h104, 32'hCAFEF00D);
        host_set(1'b1, 4'h0, 32'h80, 32'h0);
        n_st = 0;
        for (int c = 0; c <= 20; c++) begin
            if (c == 19) host_req = 1'b0;
            if (c == 20) cpu_set(4'h0, 1'b0, 32'h0, 32'h0);
            #1;
            burst = (c >= 15 && c <= 18);
            chk($sformatf("C%0d_cpuen", c), {31'h0, cpu_en}, {31'h0, ~burst});
            chk($sformatf("C%0d_mwe", c), {28'h0, mem_write_en},
                (burst || c == 20) ? 32'h0 : 32'hF);
            if (c >= 15 && mem_write_en == 4'hF && mem_addr == 32'h104) n_st++;
            step();
        end
        chk("C_store_once", 32'(n_st), 32'h1);

        // ---------------- en_in low for 3 cycles mid-burst ----------------
        do_reset();
        cpu_set(4'h0, 1'b1, 32'h100, 32'h0);
        host_set(1'b1, 4'h0, 32'h80, 32'h0);
        for (int c = 0; c <= 23; c++) begin
            en_in = !(c >= 17 && c <= 19);
            #1;
            gnt_e = (c == 15 || c == 16 || c == 20 || c == 21);
            en_e  = en_in && !(c >= 15 && c <= 21);
            chk($sformatf("D%0d_gnt", c),   {31'h0, host_gnt}, {31'h0, gnt_e});
            chk($sformatf("D%0d_cpuen", c), {31'h0, cpu_en}, {31'h0, en_e});
            chk($sformatf("D%0d_mre", c),   {31'h0, mem_read_en}, {31'h0, en_in});
            if (c >= 21) chk($sformatf("D%0d_rvalid", c), {31'h0, host_rvalid},
                             {31'h0, (c == 21 || c == 22)});
            step();
        end
        en_in = 1'b1;

        // ---------------- reset in burst cycle 2 ----------------
        do_reset();
        cpu_set(4'h0, 1'b1, 32'h100, 32'h0);
        host_set(1'b1, 4'h0, 32'h80, 32'h0);
        for (int c = 0; c <= 33; c++) begin
            rst = (c == 17);
            #1;
            gnt_e = (c == 15 || c == 16 || c == 33);
            en_e  = !rst && !gnt_e;
            chk($sformatf("E%0d_gnt", c),   {31'h0, host_gnt}, {31'h0, gnt_e});
            chk($sformatf("E%0d_cpuen", c), {31'h0, cpu_en}, {31'h0, en_e});
            if (c == 17) chk("E_rst_mre", {31'h0, mem_read_en}, 32'h0);
            if (c == 18) chk("E_rvalid_after_rst", {31'h0, host_rvalid}, 32'h0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
